// File: rtl/ring_uart_tx_if.sv
// Wishbone read-master bundle used by ring_uart_tx to fetch bytes from RAM.
// Member names keep the master-side port names of the block (o_ = driven by
// the UART, i_ = returned by the memory).
interface ring_uart_tx_if;
   logic [31:0] o_wb_adr;
   logic        o_wb_cyc;
   logic        o_wb_we;
   logic [3:0]  o_wb_sel;
   logic [31:0] i_wb_rdt;
   logic        i_wb_ack;

   modport master (
      output o_wb_adr, o_wb_cyc, o_wb_we, o_wb_sel,
      input  i_wb_rdt, i_wb_ack
   );

   modport slave (
      input  o_wb_adr, o_wb_cyc, o_wb_we, o_wb_sel,
      output i_wb_rdt, i_wb_ack
   );
endinterface

// File: rtl/ring_uart_tx.sv
// ring_uart_tx: drains a receive ring buffer in RAM over Wishbone and sends
// each byte (low byte of every ring word) out on a UART line, 8N1.
// Optional feature: define RING_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (11-bit frame).
module ring_uart_tx #(
   parameter logic [31:0] ADR_LL       = 32'h300,
   parameter logic [31:0] ADR_UL       = 32'h1FFC,
   parameter int          CLKS_PER_BIT = 104
) (
   input  logic               i_wb_clk,
   input  logic               i_wb_rst_n,
   input  logic [31:0]        i_wr_adr,
   ring_uart_tx_if.master     wb,
   output logic               o_tx,
   output logic               o_busy,
   output logic               o_sent
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
`ifdef RING_UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif
   localparam logic [2:0] S_STOP   = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [31:0]       rd_ptr_q, rd_ptr_d;
   logic              cyc_q, cyc_d;
   logic [7:0]        data_q, data_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic              tx_q, tx_d;

   logic [31:0] eff_wr_adr;
   logic        ring_empty;
   logic        baud_last;
   logic [2:0]  nxt_bit;
   logic        unused_rdt;

   // The receiver briefly shows UL+4 before wrapping; treat anything above
   // the ring as the wrapped value.
   assign eff_wr_adr = (i_wr_adr > ADR_UL) ? ADR_LL : i_wr_adr;
   assign ring_empty = (rd_ptr_q == eff_wr_adr);
   assign baud_last  = (baud_cnt_q == BAUD_LAST);
   assign nxt_bit    = bit_cnt_q + 3'd1;
   assign unused_rdt = ^wb.i_wb_rdt[31:8];

   assign wb.o_wb_adr = rd_ptr_q;
   assign wb.o_wb_cyc = cyc_q;
   assign wb.o_wb_we  = 1'b0;
   assign wb.o_wb_sel = 4'b1111;

   assign o_tx   = tx_q;
   assign o_busy = (state_q != S_IDLE);
   assign o_sent = (state_q == S_STOP) && baud_last;

   // Next-state logic: fetch one ring word, then shift its low byte out.
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      cyc_d      = cyc_q;
      data_d     = data_q;
      bit_cnt_d  = bit_cnt_q;
      baud_cnt_d = baud_cnt_q;
      tx_d       = tx_q;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!ring_empty) begin
               state_d = S_FETCH;
               cyc_d   = 1'b1;
            end
         end
         S_FETCH: begin
            if (wb.i_wb_ack) begin
               cyc_d      = 1'b0;
               data_d     = wb.i_wb_rdt[7:0];
               rd_ptr_d   = (rd_ptr_q == ADR_UL) ? ADR_LL : rd_ptr_q + 32'd4;
               state_d    = S_START;
               tx_d       = 1'b0;
               baud_cnt_d = '0;
            end
         end
         S_START: begin
            baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
            if (baud_last) begin
               state_d   = S_DATA;
               bit_cnt_d = 3'd0;
               tx_d      = data_q[0];
            end
         end
         S_DATA: begin
            baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
            if (baud_last) begin
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
`ifdef RING_UART_TX_PARITY_EN
                  state_d   = S_PARITY;
                  tx_d      = ^data_q;
`else
                  state_d   = S_STOP;
                  tx_d      = 1'b1;
`endif
               end else begin
                  bit_cnt_d = nxt_bit;
                  tx_d      = data_q[nxt_bit];
               end
            end
         end
`ifdef RING_UART_TX_PARITY_EN
         S_PARITY: begin
            baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
            if (baud_last) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            baud_cnt_d = baud_last ? '0 : baud_cnt_q + 1'b1;
            if (baud_last) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            cyc_d      = 1'b0;
            tx_d       = 1'b1;
            baud_cnt_d = '0;
            bit_cnt_d  = 3'd0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset abandons any frame.
   always_ff @(posedge i_wb_clk) begin
      if (!i_wb_rst_n) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= ADR_LL;
         cyc_q      <= 1'b0;
         data_q     <= 8'd0;
         bit_cnt_q  <= 3'd0;
         baud_cnt_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         cyc_q      <= cyc_d;
         data_q     <= data_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_ring_uart_tx.sv
// Directed bench for ring_uart_tx, CLKS_PER_BIT = 4. The ring is shortened
// to 'h300..'h308 so the top-of-ring wrap is reached in a few frames.
module tb_ring_uart_tx;
   localparam int CPB = 4;
`ifdef RING_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wr_adr = 32'h300;
   logic        o_tx, o_busy, o_sent;

   ring_uart_tx_if bus ();

   ring_uart_tx #(
      .ADR_LL(32'h300), .ADR_UL(32'h308), .CLKS_PER_BIT(CPB)
   ) dut (
      .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wr_adr(wr_adr),
      .wb(bus.slave), .o_tx(o_tx), .o_busy(o_busy), .o_sent(o_sent)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Memory responder: ack in cycle (delay+1) of a cycle, records what it saw.
   logic [31:0] mem [0:3];
   int          ack_delay = 1;
   int          cyc_cnt = 0;
   logic        resp_ack = 1'b0;
   logic        stray_ack = 1'b0;
   logic [31:0] first_adr = '0;
   logic        adr_stable = 1'b1;
   logic [3:0]  seen_sel = '0;
   logic        seen_we = 1'b1;
   logic [31:0] seen_adr = '0;
   int          seen_len = 0;

   assign bus.i_wb_ack = resp_ack | stray_ack;
   assign bus.i_wb_rdt = mem[bus.o_wb_adr[3:2]];

   always @(negedge clk) begin
      if (bus.o_wb_cyc) begin
         if (cyc_cnt == 0) begin
            first_adr  = bus.o_wb_adr;
            adr_stable = 1'b1;
         end else if (bus.o_wb_adr !== first_adr) begin
            adr_stable = 1'b0;
         end
         cyc_cnt  = cyc_cnt + 1;
         resp_ack = (cyc_cnt == ack_delay + 1);
         if (resp_ack) begin
            seen_sel = bus.o_wb_sel;
            seen_we  = bus.o_wb_we;
            seen_adr = bus.o_wb_adr;
            seen_len = cyc_cnt;
         end
      end else begin
         cyc_cnt  = 0;
         resp_ack = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the start bit, then check every cycle of the frame.
   task automatic check_frame(input logic [7:0] b);
      logic found;
      logic exp_tx;
      int   bi;
      int   sent_n;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (o_tx === 1'b0) found = 1'b1;
      end
      check("start_bit_seen", {63'd0, found}, 64'd1);
      sent_n = 0;
      for (int c = 0; c < NBITS * CPB; c++) begin
         bi = c / CPB;
         if (bi == 0)              exp_tx = 1'b0;
         else if (bi <= 8)         exp_tx = b[bi-1];
         else if (bi == NBITS - 1) exp_tx = 1'b1;
         else                      exp_tx = ^b;
         if (o_sent === 1'b1) sent_n++;
         check($sformatf("frame_%02h_c%0d", b, c), {62'd0, o_tx, o_sent},
               {62'd0, exp_tx, (c == NBITS * CPB - 1)});
         @(negedge clk);
      end
      check("sent_pulses", 64'(sent_n), 64'd1);
      check("idle_after_frame", {62'd0, o_busy, o_tx}, {62'd0, 1'b0, 1'b1});
   endtask

   task automatic expect_no_cyc(input string tag, input int n);
      int hits;
      hits = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.o_wb_cyc !== 1'b0 || o_busy !== 1'b0) hits++;
      end
      check(tag, 64'(hits), 64'd0);
   endtask

   initial begin
      mem[0] = 32'h0000_00A5;
      mem[1] = 32'h0000_00C3;
      mem[2] = 32'h0000_003C;
      mem[3] = 32'h0;

      // Reset held with an empty ring, then released.
      repeat (3) @(negedge clk);
      check("rst_hold_tx", {63'd0, o_tx}, 64'd1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_cyc", {63'd0, bus.o_wb_cyc}, 64'd0);
      check("post_rst_tx", {63'd0, o_tx}, 64'd1);
      check("post_rst_busy", {63'd0, o_busy}, 64'd0);
      check("post_rst_sent", {63'd0, o_sent}, 64'd0);
      check("post_rst_adr", {32'd0, bus.o_wb_adr}, 64'h300);

      // One byte 'hA5 at 'h300, ack after one cycle.
      ack_delay = 1;
      wr_adr = 32'h304;
      check_frame(8'hA5);
      check("a5_read_adr", {32'd0, seen_adr}, 64'h300);
      check("a5_sel", {60'd0, seen_sel}, 64'hF);
      check("a5_we", {63'd0, seen_we}, 64'd0);
      check("a5_rd_ptr", {32'd0, bus.o_wb_adr}, 64'h304);

      // Ack delayed 3 cycles: cyc/adr held for all 4 cycles.
      ack_delay = 3;
      wr_adr = 32'h308;
      check_frame(8'hC3);
      check("slow_cyc_len", 64'(seen_len), 64'd4);
      check("slow_adr_stable", {63'd0, adr_stable}, 64'd1);
      check("slow_read_adr", {32'd0, seen_adr}, 64'h304);
      check("slow_rd_ptr", {32'd0, bus.o_wb_adr}, 64'h308);

      // Top of ring: read at UL, pointer wraps to LL, ring then empty.
      ack_delay = 1;
      wr_adr = 32'h300;
      check_frame(8'h3C);
      check("wrap_read_adr", {32'd0, seen_adr}, 64'h308);
      check("wrap_rd_ptr", {32'd0, bus.o_wb_adr}, 64'h300);
      expect_no_cyc("wrap_no_more_cyc", 30);

      // Out-of-ring write pointers fold to LL: ring stays empty.
      wr_adr = 32'h2000;
      expect_no_cyc("wr_above_ul_empty", 50);
      wr_adr = 32'h30C;
      expect_no_cyc("wr_ul_plus4_empty", 20);

      // Stray ack while idle must be ignored.
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      expect_no_cyc("stray_ack_ignored", 10);
      check("stray_rd_ptr", {32'd0, bus.o_wb_adr}, 64'h300);

      // Reset during DATA bit 3 of byte 'h81, then the byte is re-read.
      mem[0] = 32'h0000_0081;
      wr_adr = 32'h304;
      begin
         logic found;
         found = 1'b0;
         for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (o_tx === 1'b0) found = 1'b1;
         end
         check("rst_frame_start", {63'd0, found}, 64'd1);
      end
      repeat (17) @(negedge clk);
      check("rst_pre_busy", {63'd0, o_busy}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_tx", {63'd0, o_tx}, 64'd1);
      check("mid_rst_cyc", {63'd0, bus.o_wb_cyc}, 64'd0);
      check("mid_rst_busy", {63'd0, o_busy}, 64'd0);
      check("mid_rst_rd_ptr", {32'd0, bus.o_wb_adr}, 64'h300);
      check_frame(8'h81);
      check("reread_rd_ptr", {32'd0, bus.o_wb_adr}, 64'h304);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ring_uart_tx.md
RING_UART_TX -- requirements
Module: ring_uart_tx

Interface
REQ-001 SHALL have parameter ADR_LL, default 'h300, lowest byte address of the receive ring in RAM.
REQ-002 SHALL have parameter ADR_UL, default 'h1FFC, highest word address of the ring, inclusive.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 104, the number of i_wb_clk cycles per UART bit.
REQ-004 SHALL have port i_wb_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_wb_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port i_wr_adr, input, 32 bits: the receive-side write pointer, i.e. the next ring address the receiver writes.
REQ-007 SHALL have port o_wb_adr, output, 32 bits: Wishbone read address.
REQ-008 SHALL have port o_wb_cyc, output, 1 bit: Wishbone cycle/strobe.
REQ-009 SHALL have port o_wb_we, output, 1 bit: tied 0.
REQ-010 SHALL have port o_wb_sel, output, 4 bits: tied 4'b1111.
REQ-011 SHALL have port i_wb_rdt, input, 32 bits: read data.
REQ-012 SHALL have port i_wb_ack, input, 1 bit: read acknowledge.
REQ-013 SHALL have port o_tx, output, 1 bit: UART serial line, idle high.
REQ-014 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port o_sent, output, 1 bit: one-cycle pulse when a stop bit completes.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, START, DATA, (PARITY), STOP.
REQ-017 rd_ptr (32 bits) SHALL drive o_wb_adr.
REQ-018 The effective write pointer SHALL be ADR_LL when i_wr_adr > ADR_UL, otherwise i_wr_adr; this covers the receiver's transient UL+4 value.
REQ-019 The ring SHALL be empty when rd_ptr equals the effective write pointer.
REQ-020 In IDLE, when the ring is non-empty, the FSM SHALL go to FETCH and assert o_wb_cyc on the next cycle.
REQ-021 In FETCH, o_wb_cyc and o_wb_adr SHALL hold stable until i_wb_ack is sampled high.
REQ-022 On ack, the FSM SHALL:
- latch i_wb_rdt[7:0];
- deassert o_wb_cyc on the next cycle;
- advance rd_ptr: ADR_LL if rd_ptr == ADR_UL, else rd_ptr + 4;
- enter START.
REQ-023 START SHALL drive o_tx = 0 for CLKS_PER_BIT cycles.
REQ-024 DATA SHALL send 8 bits, LSB first, each for CLKS_PER_BIT cycles.
REQ-025 STOP SHALL drive o_tx = 1 for CLKS_PER_BIT cycles.
REQ-026 On the last STOP cycle, o_sent SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-027 A new fetch SHALL begin no earlier than the cycle after o_sent.
REQ-028 i_wr_adr changing during a frame SHALL NOT affect the frame in progress; emptiness is re-evaluated only in IDLE.
REQ-029 The bit counter SHALL be 3 bits and the baud counter SHALL be $clog2(CLKS_PER_BIT) bits; neither SHALL wrap mid-bit.
REQ-030 An ack received outside FETCH SHALL be ignored.

Reset
REQ-031 When i_wb_rst_n = 0 at a clock edge, the block SHALL set on the next cycle:
- FSM = IDLE, rd_ptr = ADR_LL;
- o_wb_cyc = 0, o_tx = 1, o_busy = 0, o_sent = 0;
- all counters = 0.
REQ-032 Reset SHALL take effect mid-fetch or mid-frame; the partial frame is abandoned and the byte is not re-read unless rd_ptr is still equal to its address.

Configuration
REQ-033 Macro RING_UART_TX_PARITY_EN SHALL control the parity bit:
- defined: a PARITY state inserted between DATA and STOP sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame;
- undefined: there is no PARITY state and the frame is 10 bits.

Verification
REQ-034 The bench SHALL cover, with CLKS_PER_BIT = 4, the following scenarios:
- Reset held with i_wr_adr = 'h300, then released -> o_wb_cyc stays 0, o_tx = 1, o_busy = 0.
- i_wr_adr = 'h304, RAM['h300] = 'h000000A5, ack after 1 cycle -> read at 'h300 with sel 1111 and we 0; o_tx sends 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; o_sent pulses once; rd_ptr = 'h304; IDLE.
- rd_ptr = 'h1FFC, i_wr_adr = 'h300, RAM['h1FFC] = 'h3C -> one frame of 'h3C; rd_ptr wraps to 'h300; no further cyc.
- rd_ptr = 'h300, i_wr_adr = 'h2000 -> treated as empty; no cyc for 50 cycles.
- ack delayed 3 cycles -> o_wb_cyc and o_wb_adr unchanged for all 4 cycles; frame starts after ack.
- Reset pulsed in DATA bit 3 -> next cycle o_tx = 1, o_wb_cyc = 0, rd_ptr = 'h300.
- With RING_UART_TX_PARITY_EN defined, byte 'hA5 -> parity bit 0 before stop; frame lasts 44 cycles.
